// File: rtl/uart_tx_fifo_if.sv
// Byte write channel into the transmit FIFO: a producer offers data_i/valid_i,
// and the transmitter answers with ready_o.
interface uart_tx_fifo_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeds a start/data/stop
// serialiser. Queued bytes are sent back-to-back, with no idle gap between frames.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  uart_tx_fifo_if.slave                 wr,
  output logic                          TXD_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FULL      = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              r_state, w_state_next;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic [7:0]          r_shift, w_shift_next;
  logic [BAUD_W-1:0]   r_baud, w_baud_next;
  logic [2:0]          r_bit, w_bit_next;
  logic                r_txd, w_txd_next;
  logic                w_push, w_pop, w_baud_done, w_has_data;

  assign wr.ready_o  = (r_count != FULL);
  assign w_push      = wr.valid_i && wr.ready_o;
  assign w_has_data  = (r_count != '0);
  assign w_baud_done = (r_baud == BAUD_LAST);

  assign TXD_o   = r_txd;
  assign busy_o  = (r_state != IDLE) || w_has_data;
  assign count_o = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_baud_next  = w_baud_done ? '0 : r_baud + 1'b1;
    w_txd_next   = 1'b1;

    unique case (r_state)
      IDLE: begin
        w_baud_next = '0;
        if (w_has_data) begin
          w_pop        = 1'b1;
          w_bit_next   = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_baud_done) w_state_next = DATA;
      end
      DATA: begin
        if (w_baud_done) begin
          w_shift_next = r_shift >> 1;
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          if (w_has_data) begin
            w_pop        = 1'b1;
            w_bit_next   = '0;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
    endcase

    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
      w_baud_next  = '0;
    end

    // Line level is derived from the next state so the registered TXD_o
    // changes on the same edge as the state it belongs to.
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_shift <= w_shift_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_txd   <= w_txd_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr.data_i;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes queue expected line waveforms,
// and a serial monitor captures each frame and compares it against them.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FL    = 10 * CPB;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          TXD_o;
  logic          busy_o;
  logic [CW-1:0] count_o;

  uart_tx_fifo_if wr_if ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr      (wr_if),
    .TXD_o   (TXD_o),
    .busy_o  (busy_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  int         frame_starts[$];
  int         acc_counts[$];
  int         first_block;
  int         first_acc_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial monitor: a low sample on an idle line opens a frame of FL samples.
  initial begin
    logic [FL-1:0] samp;
    logic [FL-1:0] expv;
    logic [7:0]    e;
    logic          aborted;
    int            pos;
    forever begin
      @(negedge clk_i);
      if (!rst_i && TXD_o === 1'b0) begin
        frame_starts.push_back(cyc);
        samp    = '0;
        aborted = 1'b0;
        for (int i = 1; i < FL; i++) begin
          @(negedge clk_i);
          if (rst_i) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = TXD_o;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: line 0x%0h with no byte queued", samp);
          end else begin
            e = exp_q.pop_front();
            for (int j = 0; j < FL; j++) begin
              pos = j / CPB;
              if (pos == 0)      expv[j] = 1'b0;
              else if (pos == 9) expv[j] = 1'b1;
              else               expv[j] = e[pos-1];
            end
            check("frame", samp, expv);
          end
        end
      end
    end
  end

  task automatic run_stream();
    int   acc = 0;
    int   blk = 0;
    int   n   = 0;
    logic ok;
    first_block = -1;
    acc_counts.delete();
    @(posedge clk_i); #1;
    wr_if.valid_i = 1'b1;
    wr_if.data_i  = stim_q[0];
    while (acc < stim_q.size() && n < 2000) begin
      @(negedge clk_i);
      ok = wr_if.ready_o;
      if (!ok) begin
        if (first_block < 0) first_block = acc;
        if (blk < 10) begin
          check("blocked_count", 64'(count_o), 64'(DEPTH));
          blk++;
        end
      end
      @(posedge clk_i); #1;
      n++;
      if (ok) begin
        if (acc == 0) first_acc_cyc = cyc;
        exp_q.push_back(stim_q[acc]);
        acc_counts.push_back(int'(count_o));
        acc++;
        if (acc < stim_q.size()) wr_if.data_i = stim_q[acc];
      end
    end
    wr_if.valid_i = 1'b0;
    if (acc < stim_q.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: accepted %0d of %0d", acc, stim_q.size());
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (busy_o !== 1'b0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy_o still %b", busy_o);
    end
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    int n;
    int busy_drop;
    int nframes;
    int s;
    wr_if.valid_i = 1'b0;
    wr_if.data_i  = '0;

    // Reset values
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_txd",   64'(TXD_o),         64'(1));
    check("rst_ready", 64'(wr_if.ready_o), 64'(1));
    check("rst_busy",  64'(busy_o),        64'(0));
    check("rst_count", 64'(count_o),       64'(0));
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single byte: start-bit latency and busy duration
    frame_starts.delete();
    stim_q = {8'hA3};
    run_stream();
    n = 0;
    @(negedge clk_i);
    while (busy_o !== 1'b0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    busy_drop = cyc;
    check("start_latency", 64'(frame_starts.size() > 0 ? frame_starts[0] : -1), 64'(first_acc_cyc + 1));
    check("busy_drop",     64'(busy_drop), 64'(first_acc_cyc + 1 + FL));
    wait_idle();

    // Burst of three on consecutive cycles
    frame_starts.delete();
    stim_q = {8'h00, 8'hFF, 8'h55};
    run_stream();
    check("burst_count0", 64'(acc_counts[0]), 64'(1));
    check("burst_count1", 64'(acc_counts[1]), 64'(1));
    check("burst_count2", 64'(acc_counts[2]), 64'(2));
    wait_idle();
    check("burst_frames", 64'(frame_starts.size()), 64'(3));
    if (frame_starts.size() == 3) begin
      check("burst_gap1", 64'(frame_starts[1] - frame_starts[0]), 64'(FL));
      check("burst_gap2", 64'(frame_starts[2] - frame_starts[1]), 64'(FL));
    end

    // Full FIFO with valid_i held high; also covers writes ignored while not ready
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(8'(8'h10 + i));
    run_stream();
    check("full_accepts", 64'(first_block), 64'(DEPTH + 1));
    wait_idle();

    // Pointer wrap-around with random data
    stim_q.delete();
    for (int i = 0; i < 3 * DEPTH + 1; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    run_stream();
    wait_idle();
    check("wrap_drained", 64'(exp_q.size()), 64'(0));

    // Reset during data bit 3 with two bytes queued
    frame_starts.delete();
    stim_q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_stream();
    n = 0;
    while (frame_starts.size() == 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (frame_starts.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL reset_frame_start: no frame began");
      s = cyc;
    end else begin
      s = frame_starts[0];
    end
    while (cyc < s + 4 * CPB + 1) @(posedge clk_i);
    #3;
    check("pre_reset_count", 64'(count_o), 64'(2));
    rst_i = 1'b1;
    #1;
    check("midrst_txd",   64'(TXD_o),         64'(1));
    check("midrst_count", 64'(count_o),       64'(0));
    check("midrst_busy",  64'(busy_o),        64'(0));
    check("midrst_ready", 64'(wr_if.ready_o), 64'(1));
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    nframes = frame_starts.size();
    repeat (100) @(negedge clk_i);
    check("post_reset_frames", 64'(frame_starts.size()), 64'(nframes));
    check("post_reset_txd",    64'(TXD_o),  64'(1));
    check("post_reset_busy",   64'(busy_o), 64'(0));

    // A fresh write after reset goes out normally
    stim_q = {8'h5A};
    run_stream();
    wait_idle();

    check("leftover_expected", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
